iterative_muldiv_unit: RTL and testbench

ITERATIVE_MULDIV_UNIT -- requirements
Module: iterative_muldiv_unit

---
 rtl/iterative_muldiv_unit.sv | 94 +++++++++
 tb/tb_iterative_muldiv_unit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/iterative_muldiv_unit.sv
// iterative_muldiv_unit: 32-bit RV32M multiply/divide, radix-2 shift-add and restoring division
module iterative_muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic [4:0]  operation,
  output logic        busy,
  output logic        done,
  output logic [31:0] res
);
  localparam logic [2:0] S_IDLE = 3'd0, S_MUL = 3'd1, S_DIV = 3'd2, S_FIX = 3'd3, S_DONE = 3'd4;
  logic [2:0]  r_state;
  logic [5:0]  r_cnt;
  logic [31:0] r_hi, r_lo, r_mc;
  logic        r_neg;
  logic [1:0]  r_sel;
  logic w_mul, w_mulh, w_mulhu, w_mulhsu, w_div, w_divu, w_rem, w_remu;
  logic w_is_mul, w_is_div, w_accept, w_zero, w_s1, w_s2, w_neg, w_ge;
  logic [1:0]  w_sel;
  logic [31:0] w_a1, w_a2, w_q, w_r;
  logic [32:0] w_sum, w_trial;
  logic [63:0] w_prod;
  assign w_mul    = operation == 5'b10000;
  assign w_mulh   = operation == 5'b11000;
  assign w_mulhu  = operation == 5'b11001;
  assign w_mulhsu = operation == 5'b11010;
  assign w_div    = operation == 5'b10011;
  assign w_divu   = operation == 5'b10100;
  assign w_rem    = operation == 5'b10101;
  assign w_remu   = operation == 5'b10111;
  assign w_is_mul = w_mul | w_mulh | w_mulhu | w_mulhsu;
  assign w_is_div = w_div | w_divu | w_rem | w_remu;
  assign w_accept = start && r_state == S_IDLE && (w_is_mul || w_is_div);
  assign w_zero   = w_is_div && in2 == 32'd0;
  // mul is taken unsigned: its low product word does not depend on operand signs
  assign w_s1  = in1[31] & (w_mulh | w_mulhsu | w_div | w_rem);
  assign w_s2  = in2[31] & (w_mulh | w_div | w_rem);
  assign w_a1  = w_s1 ? -in1 : in1;
  assign w_a2  = w_s2 ? -in2 : in2;
  assign w_neg = (w_rem | w_remu) ? w_s1 : w_s1 ^ w_s2;
  assign w_sel = w_mul ? 2'd0 : w_is_mul ? 2'd1 : (w_div | w_divu) ? 2'd2 : 2'd3;
  // r_hi/r_lo hold product high/low while multiplying, partial remainder/quotient while dividing
  assign w_sum   = {1'b0, r_hi} + {1'b0, r_lo[0] ? r_mc : 32'd0};
  assign w_trial = {r_hi, r_lo[31]} - {1'b0, r_mc};
  assign w_ge    = !w_trial[32];
  assign w_prod  = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};
  assign w_q     = r_neg ? -r_lo : r_lo;
  assign w_r     = r_neg ? -r_hi : r_hi;
  assign busy = r_state != S_IDLE;
  assign done = r_state == S_DONE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_mc    <= '0;
      r_neg   <= 1'b0;
      r_sel   <= '0;
      res     <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_cnt <= '0;
          r_neg <= w_neg;
          r_sel <= w_sel;
          r_hi  <= '0;
          r_lo  <= w_is_mul ? w_a2 : w_a1;
          r_mc  <= w_is_mul ? w_a1 : w_a2;
          if (w_zero) res <= (w_div | w_divu) ? 32'hFFFF_FFFF : in1;
          r_state <= w_zero ? S_DONE : w_is_mul ? S_MUL : S_DIV;
        end
        S_MUL: begin
          {r_hi, r_lo} <= {w_sum, r_lo[31:1]};
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd31) r_state <= S_FIX;
        end
        S_DIV: begin
          r_hi  <= w_ge ? w_trial[31:0] : {r_hi[30:0], r_lo[31]};
          r_lo  <= {r_lo[30:0], w_ge};
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd31) r_state <= S_FIX;
        end
        S_FIX: begin
          res <= r_sel == 2'd0 ? w_prod[31:0] : r_sel == 2'd1 ? w_prod[63:32] : r_sel == 2'd2 ? w_q : w_r;
          r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iterative_muldiv_unit.sv
// tb_iterative_muldiv_unit: directed and randomised checks with a result/latency scoreboard
module tb_iterative_muldiv_unit;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [31:0] in1 = '0, in2 = '0;
  logic [4:0]  operation = '0;
  logic        busy, done;
  logic [31:0] res;
  int errors = 0, checks = 0;
  logic [31:0] q_res[$];
  int          q_lat[$];
  logic [31:0] last_res = '0;

  iterative_muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2),
    .operation(operation), .busy(busy), .done(done), .res(res)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [63:0] ea, eb;
    ea = {{32{a[31]}}, a};
    eb = {{32{b[31]}}, b};
    case (op)
      5'b10000: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      5'b11000: begin p = ea * eb; return p[63:32]; end
      5'b11001: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      5'b11010: begin p = ea * {32'd0, b}; return p[63:32]; end
      5'b10011: return b == 0 ? 32'hFFFF_FFFF : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : $signed(a) / $signed(b);
      5'b10100: return b == 0 ? 32'hFFFF_FFFF : a / b;
      5'b10101: return b == 0 ? a : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : $signed(a) % $signed(b);
      5'b10111: return b == 0 ? a : a % b;
      default:  return 32'd0;
    endcase
  endfunction

  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string tag, input bit scramble);
    int  cnt;
    bit  got;
    @(negedge clk);
    operation = op; in1 = a; in2 = b; start = 1'b1;
    q_res.push_back(exp);
    q_lat.push_back(lat);
    @(posedge clk);
    #1 start = 1'b0;
    cnt = 0; got = 0;
    while (!got && cnt < 60) begin
      @(negedge clk);
      cnt++;
      if (scramble && cnt == 5) begin
        in1 = $urandom; in2 = $urandom; operation = 5'b10100; start = 1'b1;
      end
      if (scramble && cnt == 6) start = 1'b0;
      if (done) got = 1;
    end
    chk({tag, "_done_seen"}, 64'(got), 64'd1);
    chk({tag, "_latency"}, 64'(cnt), 64'(q_lat.pop_front()));
    last_res = q_res.pop_front();
    chk({tag, "_res"}, 64'(res), 64'(last_res));
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd1);
    operation = 5'b10000; in1 = 32'd9; in2 = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_idle_after_done"}, {62'd0, busy, done}, 64'd0);
    chk({tag, "_res_hold"}, 64'(res), 64'(last_res));
  endtask

  initial begin
    logic [4:0] codes[8];
    logic [4:0] op;
    logic [31:0] a, b;
    bit seen;
    codes = '{5'b10000, 5'b11000, 5'b11001, 5'b11010, 5'b10011, 5'b10100, 5'b10101, 5'b10111};
    #1;
    chk("reset_state", {29'd0, busy, done, 1'b0, 32'd0} | {32'd0, res}, 64'd0);
    #20 rst = 1'b0;

    run_op(5'b10000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "mul_7_m3", 0);
    run_op(5'b11000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, "mulh", 0);
    run_op(5'b11001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu", 0);
    run_op(5'b11010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, "mulhsu", 0);
    run_op(5'b10011, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, "div_m7_2", 0);
    run_op(5'b10101, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, "rem_m7_2", 0);
    run_op(5'b10111, 32'd7, 32'd0, 32'd7, 1, "remu_by0", 0);
    run_op(5'b10100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu_by0", 0);
    run_op(5'b10011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, "div_ovf", 0);
    run_op(5'b10101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34, "rem_ovf", 0);
    run_op(5'b10011, 32'd100, 32'd0, 32'hFFFF_FFFF, 1, "div_by0", 0);
    run_op(5'b10101, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FF9C, 1, "rem_by0", 0);

    // unsupported code must be ignored
    @(negedge clk);
    operation = 5'b00000; in1 = 32'd1; in2 = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("add_ignored", {62'd0, busy, done}, 64'd0);
    end
    chk("add_res_hold", 64'(res), 64'(last_res));

    run_op(5'b10011, 32'hFFFF_FC18, 32'd7, 32'hFFFF_FF72, 34, "div_scramble", 1);
    run_op(5'b11001, 32'h1234_5678, 32'h9ABC_DEF0, ref_res(5'b11001, 32'h1234_5678, 32'h9ABC_DEF0), 34, "mulhu_scramble", 1);

    for (int i = 0; i < 10; i++) begin
      op = codes[$urandom_range(7)];
      a = $urandom;
      b = (i == 3) ? 32'd0 : (i % 2) ? $urandom : 32'($urandom_range(1, 300));
      run_op(op, a, b, ref_res(op, a, b), (op[4:3] == 2'b10 && op != 5'b10000 && b == 0) ? 1 : 34, "rand", 0);
    end

    // reset during a divide aborts it
    @(negedge clk);
    operation = 5'b10011; in1 = 32'd1000; in2 = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    chk("busy_before_rst", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_busy_done", {62'd0, busy, done}, 64'd0);
    chk("rst_res", 64'(res), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    chk("no_done_after_rst", 64'(seen), 64'd0);
    run_op(5'b10000, 32'd3, 32'd4, 32'd12, 34, "mul_after_rst", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
